// File: rtl/bolme_div_pkg.sv
// ============================================================================
// Module      : bolme_div_pkg
// Description : Shared calculator widths, fixed-point constants and divider
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bolme_div_pkg;

    localparam int OPERAND_W     = 32;
    localparam int FRAC_W        = 16;
    localparam int RESULT_W      = 64;
    localparam int RESULT_FRAC_W = 32;

    localparam logic [OPERAND_W-1:0] ONE_Q16 = 32'h0001_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DIVZERO = 2'd2
    } state_e;

endpackage : bolme_div_pkg

`default_nettype wire

// File: rtl/bolme_div.sv
// ============================================================================
// Module      : bolme_div
// Description : Free-running restoring divider, Q16.16 / Q16.16 -> Q32.32,
//               one quotient bit per clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bolme_div
    import bolme_div_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [OPERAND_W-1:0] bolunen,
    input  logic [OPERAND_W-1:0] bolen,
    output logic [RESULT_W-1:0]  sonuc,
    output logic                 hazir,
    output logic                 gecerli,
    output logic                 tasma
);

    state_e                 r_state;
    logic [RESULT_W-1:0]    r_dvd;      // dividend shifts out, quotient shifts in
    logic [OPERAND_W-1:0]   r_dvs;
    logic [OPERAND_W-1:0]   r_rem;
    logic [6:0]             r_cnt;
    logic [RESULT_W-1:0]    r_sonuc;
    logic                   r_hazir;
    logic                   r_gecerli;
    logic                   r_tasma;

    logic [OPERAND_W:0]     w_rem_sh;
    logic [OPERAND_W:0]     w_diff;
    logic                   w_ge;
    logic [OPERAND_W-1:0]   w_rem_nx;
    logic [RESULT_W-1:0]    w_dvd_nx;

    // The remainder is always below the divisor, so the difference fits in
    // 32 bits when non-negative; bit 32 of the 33-bit difference is the borrow.
    assign w_rem_sh = {r_rem, r_dvd[RESULT_W-1]};
    assign w_diff   = w_rem_sh - {1'b0, r_dvs};
    assign w_ge     = ~w_diff[OPERAND_W];
    assign w_rem_nx = w_ge ? w_diff[OPERAND_W-1:0] : w_rem_sh[OPERAND_W-1:0];
    assign w_dvd_nx = {r_dvd[RESULT_W-2:0], w_ge};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_dvd     <= '0;
            r_dvs     <= '0;
            r_rem     <= '0;
            r_cnt     <= '0;
            r_sonuc   <= '0;
            r_hazir   <= 1'b1;
            r_gecerli <= 1'b0;
            r_tasma   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_dvd   <= {bolunen, {RESULT_FRAC_W{1'b0}}};
                    r_dvs   <= bolen;
                    r_rem   <= '0;
                    r_cnt   <= '0;
                    r_hazir <= 1'b0;
                    r_state <= (bolen == '0) ? DIVZERO : BUSY;
                end
                BUSY: begin
                    r_dvd <= w_dvd_nx;
                    r_rem <= w_rem_nx;
                    r_cnt <= r_cnt + 7'd1;
                    if (r_cnt == 7'd63) begin
                        r_sonuc   <= w_dvd_nx;
                        r_gecerli <= 1'b1;
                        r_tasma   <= 1'b0;
                        r_hazir   <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                DIVZERO: begin
                    r_sonuc   <= '1;
                    r_gecerli <= 1'b0;
                    r_tasma   <= 1'b1;
                    r_hazir   <= 1'b1;
                    r_state   <= IDLE;
                end
                default: begin
                    r_hazir <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign sonuc   = r_sonuc;
    assign hazir   = r_hazir;
    assign gecerli = r_gecerli;
    assign tasma   = r_tasma;

endmodule : bolme_div

`default_nettype wire

// File: tb/tb_bolme_div.sv
// ============================================================================
// Module      : tb_bolme_div
// Description : Directed-vector self-checking bench for bolme_div.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bolme_div;
    import bolme_div_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] bolunen;
    logic [31:0] bolen;
    logic [63:0] sonuc;
    logic        hazir;
    logic        gecerli;
    logic        tasma;

    int n_cmp = 0;
    int n_err = 0;
    int busy;

    bolme_div u_dut (
        .clk     (clk),
        .rst     (rst),
        .bolunen (bolunen),
        .bolen   (bolen),
        .sonuc   (sonuc),
        .hazir   (hazir),
        .gecerli (gecerli),
        .tasma   (tasma)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%016h expected 0x%016h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with hazir=1; returns at the negedge where hazir
    // rises again, having counted the low cycles and watched sonuc hold.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input int chg_at, input logic [31:0] chg_b,
                          output int nbusy);
        logic [63:0] prev;
        logic        stable;
        nbusy   = 0;
        stable  = 1'b1;
        prev    = sonuc;
        bolunen = a;
        bolen   = b;
        @(posedge clk);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (hazir) break;
            nbusy++;
            if (sonuc !== prev) stable = 1'b0;
            if (nbusy == chg_at) bolen = chg_b;
        end
        chk("hold", {63'd0, stable}, 64'd1);
    endtask

    initial begin
        rst     = 1'b1;
        bolunen = ONE_Q16;
        bolen   = 32'h0002_0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hazir",   {63'd0, hazir},   64'd1);
        chk("rst_sonuc",   sonuc,            64'd0);
        chk("rst_gecerli", {63'd0, gecerli}, 64'd0);
        chk("rst_tasma",   {63'd0, tasma},   64'd0);
        rst = 1'b0;

        run_op(ONE_Q16, 32'h0002_0000, -1, 32'h0, busy);
        chk("half_q",   sonuc,            64'h0000_0000_8000_0000);
        chk("half_gec", {63'd0, gecerli}, 64'd1);
        chk("half_tas", {63'd0, tasma},   64'd0);
        chk("half_lat", 64'(busy),        64'd64);

        run_op(32'h0003_0000, 32'h0003_0000, -1, 32'h0, busy);
        chk("one_q",   sonuc,     64'h0000_0001_0000_0000);
        chk("one_lat", 64'(busy), 64'd64);

        run_op(32'hFFFF_FFFF, 32'h0000_0001, -1, 32'h0, busy);
        chk("max_q", sonuc, 64'hFFFF_FFFF_0000_0000);

        run_op(ONE_Q16, 32'h0, -1, 32'h0, busy);
        chk("dz_q",   sonuc,            64'hFFFF_FFFF_FFFF_FFFF);
        chk("dz_tas", {63'd0, tasma},   64'd1);
        chk("dz_gec", {63'd0, gecerli}, 64'd0);
        chk("dz_lat", 64'(busy),        64'd1);

        run_op(ONE_Q16, 32'h0002_0000, -1, 32'h0, busy);
        chk("rec_q",   sonuc,            64'h0000_0000_8000_0000);
        chk("rec_tas", {63'd0, tasma},   64'd0);
        chk("rec_gec", {63'd0, gecerli}, 64'd1);

        run_op(ONE_Q16, 32'h0002_0000, 10, 32'h0004_0000, busy);
        chk("chg_q1", sonuc, 64'h0000_0000_8000_0000);
        run_op(ONE_Q16, 32'h0004_0000, -1, 32'h0, busy);
        chk("chg_q2", sonuc, 64'h0000_0000_4000_0000);

        // Abort a 5.0/2.0 division partway through with reset.
        bolunen = 32'h0005_0000;
        bolen   = 32'h0002_0000;
        @(posedge clk);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_hazir",   {63'd0, hazir},   64'd1);
        chk("abort_sonuc",   sonuc,            64'd0);
        chk("abort_gecerli", {63'd0, gecerli}, 64'd0);
        chk("abort_tasma",   {63'd0, tasma},   64'd0);
        rst = 1'b0;

        run_op(32'h0000_8000, 32'h0003_0000, -1, 32'h0, busy);
        chk("post_q",   sonuc,            64'h0000_0000_2AAA_AAAA);
        chk("post_gec", {63'd0, gecerli}, 64'd1);
        chk("post_lat", 64'(busy),        64'd64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_bolme_div

`default_nettype wire
